// File: rtl/cs_match_pipe.sv
// cs_match_pipe
// -----------------------------------------------------------------------------
// Programmable control-store select. It holds ENTRIES rows of
// {enable, key, care-mask, control word} in a register table that is loaded
// through a config port. An opcode key (opcode byte plus ModRM reg field) is
// matched against every enabled row, and the lowest matching index wins. The
// chosen control word comes back through a 2-stage valid/ready pipeline:
//   S1 : registered match vector
//   S2 : registered hit / multi / index / word (the output register)
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-low reset
//   cfg_we/idx/vld/key/mask/word
//                   row write; refused while a lookup is in flight or idx out
//                   of range
//   cfg_busy        pipeline holds a lookup (writes refused)
//   cfg_err         one-cycle pulse after a refused write
//   in_valid/ready/key
//                   lookup request handshake
//   out_valid/ready result handshake
//   out_word/idx/hit/multi
//                   selected row result (word and idx are 0 on a miss)
//
// Optional build macro: CS_MISS_CNT_EN
//   When defined, adds input cnt_clr and output miss_cnt[15:0]. The counter
//   counts delivered miss results, saturates at 16'hFFFF, and is cleared
//   synchronously by cnt_clr (the clear wins over an increment).
// -----------------------------------------------------------------------------
module cs_match_pipe #(
    parameter int ENTRIES = 140,
    parameter int KEYW    = 11,
    parameter int CWW     = 228,
    parameter int IDXW    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_we,
    input  logic [IDXW-1:0] cfg_idx,
    input  logic            cfg_vld,
    input  logic [KEYW-1:0] cfg_key,
    input  logic [KEYW-1:0] cfg_mask,
    input  logic [CWW-1:0]  cfg_word,
    output logic            cfg_busy,
    output logic            cfg_err,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [KEYW-1:0] in_key,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CWW-1:0]  out_word,
    output logic [IDXW-1:0] out_idx,
    output logic            out_hit,
`ifdef CS_MISS_CNT_EN
    output logic            out_multi,
    input  logic            cnt_clr,
    output logic [15:0]     miss_cnt
`else
    output logic            out_multi
`endif
);

    // Row count at index width plus one bit, so ENTRIES = 2^IDXW still fits.
    localparam logic [IDXW:0] ENTRIES_W = ENTRIES[IDXW:0];

    // Row table
    logic                vld_r  [ENTRIES];
    logic [KEYW-1:0]     key_r  [ENTRIES];
    logic [KEYW-1:0]     mask_r [ENTRIES];
    logic [CWW-1:0]      word_r [ENTRIES];

    // Pipeline state
    logic                s1_valid_r;
    logic [ENTRIES-1:0]  s1_match_r;
    logic                out_valid_r;
    logic                out_hit_r;
    logic                out_multi_r;
    logic [IDXW-1:0]     out_idx_r;
    logic [CWW-1:0]      out_word_r;
    logic                cfg_err_r;

    // Combinational helpers
    logic [ENTRIES-1:0]  match_s;
    logic                adv2_s;
    logic                accept_s;
    logic                in_ready_s;
    logic                busy_s;
    logic                idx_ok_s;
    logic                wr_ok_s;
    logic                wr_err_s;
    logic                sel_hit_s;
    logic                sel_multi_s;
    logic [IDXW-1:0]     sel_idx_s;
    logic [CWW-1:0]      sel_word_s;

    // Handshake and config-write qualification
    always_comb begin
        busy_s     = s1_valid_r | out_valid_r;
        adv2_s     = s1_valid_r & (~out_valid_r | out_ready);
        // A pending write blocks entry so no lookup sees a half-updated table.
        in_ready_s = (~s1_valid_r | adv2_s) & ~cfg_we;
        accept_s   = in_valid & in_ready_s;
        idx_ok_s   = ({1'b0, cfg_idx} < ENTRIES_W);
        wr_ok_s    = cfg_we & ~busy_s & idx_ok_s;
        wr_err_s   = cfg_we & ~wr_ok_s;
    end

    // Match every row against the incoming key
    always_comb begin
        match_s = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (vld_r[i] && (((in_key ^ key_r[i]) & mask_r[i]) == '0)) begin
                match_s[i] = 1'b1;
            end else begin
                match_s[i] = 1'b0;
            end
        end
    end

    // Priority pick over the S1 match vector: lowest index wins
    always_comb begin
        sel_hit_s   = 1'b0;
        sel_multi_s = 1'b0;
        sel_idx_s   = '0;
        sel_word_s  = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (s1_match_r[i]) begin
                if (sel_hit_s) begin
                    sel_multi_s = 1'b1;
                end else begin
                    sel_hit_s  = 1'b1;
                    sel_idx_s  = IDXW'(i);
                    sel_word_s = word_r[i];
                end
            end else begin
                sel_multi_s = sel_multi_s;
            end
        end
    end

    // Row table storage and config writes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                vld_r[i]  <= 1'b0;
                key_r[i]  <= '0;
                mask_r[i] <= '0;
                word_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (wr_ok_s && (cfg_idx == IDXW'(i))) begin
                    vld_r[i]  <= cfg_vld;
                    key_r[i]  <= cfg_key;
                    mask_r[i] <= cfg_mask;
                    word_r[i] <= cfg_word;
                end
            end
        end
    end

    // Config error pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_err_r <= 1'b0;
        end else begin
            cfg_err_r <= wr_err_s;
        end
    end

    // Stage 1: capture the match vector on acceptance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_r <= 1'b0;
            s1_match_r <= '0;
        end else if (accept_s) begin
            s1_valid_r <= 1'b1;
            s1_match_r <= match_s;
        end else if (adv2_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    // Stage 2: output register, held while the consumer stalls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_r <= 1'b0;
            out_hit_r   <= 1'b0;
            out_multi_r <= 1'b0;
            out_idx_r   <= '0;
            out_word_r  <= '0;
        end else if (adv2_s) begin
            out_valid_r <= 1'b1;
            out_hit_r   <= sel_hit_s;
            out_multi_r <= sel_multi_s;
            out_idx_r   <= sel_idx_s;
            out_word_r  <= sel_word_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

`ifdef CS_MISS_CNT_EN
    logic [15:0] miss_cnt_r;

    // Saturating count of delivered miss results
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            miss_cnt_r <= 16'h0000;
        end else if (cnt_clr) begin
            miss_cnt_r <= 16'h0000;
        end else if (out_valid_r && out_ready && !out_hit_r && (miss_cnt_r != 16'hFFFF)) begin
            miss_cnt_r <= miss_cnt_r + 16'h0001;
        end
    end

    assign miss_cnt = miss_cnt_r;
`endif

    assign cfg_busy  = busy_s;
    assign cfg_err   = cfg_err_r;
    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_hit   = out_hit_r;
    assign out_multi = out_multi_r;
    assign out_idx   = out_idx_r;
    assign out_word  = out_word_r;

endmodule

// File: tb/tb_cs_match_pipe.sv
// Directed bench for cs_match_pipe (default build, default parameters).
module tb_cs_match_pipe;

    localparam int KEYW = 11;
    localparam int CWW  = 228;
    localparam int IDXW = 8;

    localparam logic [CWW-1:0] W5   = 228'hA5A5_0000_DEAD_BEEF_0005;
    localparam logic [CWW-1:0] W3   = 228'h3333_3333_0003;
    localparam logic [CWW-1:0] W7   = 228'h7777_7777_0007;
    localparam logic [CWW-1:0] WNEW = 228'hFEED_FACE_00FF;
    localparam logic [CWW-1:0] W0   = 228'h0;

    logic            clk = 1'b0;
    logic            rst;
    logic            cfg_we;
    logic [IDXW-1:0] cfg_idx;
    logic            cfg_vld;
    logic [KEYW-1:0] cfg_key;
    logic [KEYW-1:0] cfg_mask;
    logic [CWW-1:0]  cfg_word;
    logic            cfg_busy;
    logic            cfg_err;
    logic            in_valid;
    logic            in_ready;
    logic [KEYW-1:0] in_key;
    logic            out_valid;
    logic            out_ready;
    logic [CWW-1:0]  out_word;
    logic [IDXW-1:0] out_idx;
    logic            out_hit;
    logic            out_multi;

    int checks = 0;
    int errors = 0;

    cs_match_pipe dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_vld(cfg_vld), .cfg_key(cfg_key),
        .cfg_mask(cfg_mask), .cfg_word(cfg_word), .cfg_busy(cfg_busy), .cfg_err(cfg_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .out_idx(out_idx), .out_hit(out_hit), .out_multi(out_multi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [IDXW-1:0] idx, input logic vld, input logic [KEYW-1:0] key,
                      input logic [KEYW-1:0] mask, input logic [CWW-1:0] word);
        cfg_we = 1'b1; cfg_idx = idx; cfg_vld = vld; cfg_key = key; cfg_mask = mask; cfg_word = word;
        step();
        cfg_we = 1'b0;
    endtask

    // Issue one lookup into an empty pipe with out_ready high; returns just after the result edge.
    task automatic lookup(input string tag, input logic [KEYW-1:0] key);
        in_valid = 1'b1; in_key = key;
        step();
        in_valid = 1'b0;
        chk({tag, "_lat1_valid"}, {255'b0, out_valid}, {255'b0, 1'b0});
        step();
        chk({tag, "_valid"}, {255'b0, out_valid}, {255'b0, 1'b1});
    endtask

    initial begin
        rst = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_vld = 1'b0; cfg_key = '0;
        cfg_mask = '0; cfg_word = '0; in_valid = 1'b0; in_key = '0; out_ready = 1'b1;
        step(); step();
        chk("rst_out_valid", {255'b0, out_valid}, {255'b0, 1'b0});
        chk("rst_in_ready",  {255'b0, in_ready},  {255'b0, 1'b1});
        chk("rst_busy",      {255'b0, cfg_busy},  {255'b0, 1'b0});
        chk("rst_err",       {255'b0, cfg_err},   {255'b0, 1'b0});
        chk("rst_word",      {28'b0, out_word},   {28'b0, W0});
        chk("rst_idx",       {248'b0, out_idx},   256'd0);
        chk("rst_hit",       {255'b0, out_hit},   {255'b0, 1'b0});
        rst = 1'b1;
        step();

        // Single masked row
        wr(8'd5, 1'b1, 11'h400, 11'h7F8, W5);
        chk("wr5_err", {255'b0, cfg_err}, {255'b0, 1'b0});
        lookup("row5", 11'h403);
        chk("row5_hit",   {255'b0, out_hit},   {255'b0, 1'b1});
        chk("row5_idx",   {248'b0, out_idx},   256'd5);
        chk("row5_word",  {28'b0, out_word},   {28'b0, W5});
        chk("row5_multi", {255'b0, out_multi}, {255'b0, 1'b0});
        step();
        chk("row5_drain", {255'b0, out_valid}, {255'b0, 1'b0});

        // Two catch-all rows: lowest index wins, multi set
        wr(8'd3, 1'b1, 11'h000, 11'h000, W3);
        wr(8'd7, 1'b1, 11'h7FF, 11'h000, W7);
        lookup("multi", 11'h123);
        chk("multi_hit",   {255'b0, out_hit},   {255'b0, 1'b1});
        chk("multi_idx",   {248'b0, out_idx},   256'd3);
        chk("multi_word",  {28'b0, out_word},   {28'b0, W3});
        chk("multi_multi", {255'b0, out_multi}, {255'b0, 1'b1});
        step();

        // Disable catch-all rows; key 0 misses row 5 on bit 10
        wr(8'd3, 1'b0, 11'h000, 11'h000, W3);
        wr(8'd7, 1'b0, 11'h000, 11'h000, W7);
        lookup("miss", 11'h000);
        chk("miss_hit",   {255'b0, out_hit},   {255'b0, 1'b0});
        chk("miss_idx",   {248'b0, out_idx},   256'd0);
        chk("miss_word",  {28'b0, out_word},   {28'b0, W0});
        chk("miss_multi", {255'b0, out_multi}, {255'b0, 1'b0});
        step();

        // Backpressure: A=hit, B=miss, C=hit
        out_ready = 1'b0;
        in_valid = 1'b1; in_key = 11'h401;
        step();                              // A accepted
        in_key = 11'h000; #1;
        chk("bp_ready_a", {255'b0, in_ready}, {255'b0, 1'b1});
        step();                              // A -> S2, B accepted
        in_key = 11'h407; #1;
        chk("bp_ready_full", {255'b0, in_ready},  {255'b0, 1'b0});
        chk("bp_a_valid",    {255'b0, out_valid}, {255'b0, 1'b1});
        chk("bp_a_idx",      {248'b0, out_idx},   256'd5);
        chk("bp_busy",       {255'b0, cfg_busy},  {255'b0, 1'b1});
        step();
        step();
        chk("bp_hold_ready", {255'b0, in_ready},  {255'b0, 1'b0});
        chk("bp_hold_valid", {255'b0, out_valid}, {255'b0, 1'b1});
        chk("bp_hold_hit",   {255'b0, out_hit},   {255'b0, 1'b1});
        chk("bp_hold_word",  {28'b0, out_word},   {28'b0, W5});
        out_ready = 1'b1; #1;
        chk("bp_rel_ready",  {255'b0, in_ready},  {255'b0, 1'b1});
        step();                              // A delivered, B -> S2, C accepted
        in_valid = 1'b0;
        chk("bp_b_valid", {255'b0, out_valid}, {255'b0, 1'b1});
        chk("bp_b_hit",   {255'b0, out_hit},   {255'b0, 1'b0});
        chk("bp_b_word",  {28'b0, out_word},   {28'b0, W0});
        step();
        chk("bp_c_valid", {255'b0, out_valid}, {255'b0, 1'b1});
        chk("bp_c_hit",   {255'b0, out_hit},   {255'b0, 1'b1});
        chk("bp_c_idx",   {248'b0, out_idx},   256'd5);
        step();
        chk("bp_empty",   {255'b0, out_valid}, {255'b0, 1'b0});

        // Refused write while a result is held
        out_ready = 1'b0;
        in_valid = 1'b1; in_key = 11'h401;
        step();
        in_valid = 1'b0;
        step();
        chk("busy_valid", {255'b0, out_valid}, {255'b0, 1'b1});
        cfg_we = 1'b1; cfg_idx = 8'd5; cfg_vld = 1'b1; cfg_key = 11'h400;
        cfg_mask = 11'h7F8; cfg_word = WNEW; #1;
        chk("we_blocks_ready", {255'b0, in_ready}, {255'b0, 1'b0});
        step();
        cfg_we = 1'b0;
        chk("busy_err_pulse", {255'b0, cfg_err}, {255'b0, 1'b1});
        out_ready = 1'b1;
        step();
        chk("busy_err_clear", {255'b0, cfg_err}, {255'b0, 1'b0});
        chk("busy_drained",   {255'b0, out_valid}, {255'b0, 1'b0});

        // Out-of-range index
        wr(8'd200, 1'b1, 11'h401, 11'h7FF, WNEW);
        chk("oor_err_pulse", {255'b0, cfg_err}, {255'b0, 1'b1});
        step();
        chk("oor_err_clear", {255'b0, cfg_err}, {255'b0, 1'b0});
        lookup("old", 11'h401);
        chk("old_word", {28'b0, out_word}, {28'b0, W5});
        chk("old_idx",  {248'b0, out_idx}, 256'd5);
        step();

        // Reset with both stages full
        out_ready = 1'b0;
        in_valid = 1'b1; in_key = 11'h401;
        step();
        step();
        in_valid = 1'b0;
        chk("full_busy", {255'b0, cfg_busy}, {255'b0, 1'b1});
        rst = 1'b0; #1;
        chk("mrst_valid", {255'b0, out_valid}, {255'b0, 1'b0});
        chk("mrst_ready", {255'b0, in_ready},  {255'b0, 1'b1});
        chk("mrst_busy",  {255'b0, cfg_busy},  {255'b0, 1'b0});
        step();
        rst = 1'b1; out_ready = 1'b1;
        step();
        lookup("cleared", 11'h401);
        chk("cleared_hit",  {255'b0, out_hit},  {255'b0, 1'b0});
        chk("cleared_word", {28'b0, out_word},  {28'b0, W0});
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
